data_mem_block: RTL and testbench
=================================

// Module: data_mem_block
// PURPOSE
// - Block-organised data memory answering the data cache's miss/write-back port.
// - Serves whole 32-bit blocks (4 x 8-bit words) addressed by 6-bit block address {tag,index}.
// - Models fixed multi-cycle main-memory latency behind a BUSYWAIT handshake that the cache FSM polls.
// PARAMETERS
// - ADDR_W   6   block address width; depth = 2**ADDR_W blocks
// - BLOCK_W  32  block width in bits
// - LATENCY  5   cycles spent in ACCESS per request; legal range 1..15
// PORTS
// - CLK        in   1        clock, all state on rising edge
// - RESET      in   1        synchronous, active-high
// - READ       in   1        block read request, held by requester until BUSYWAIT low
// - WRITE      in   1        block write request, held by requester until BUSYWAIT low
// - ADDRESS    in   ADDR_W   block address
// - WRITEDATA  in   BLOCK_W  block to store on WRITE
// - READDATA   out  BLOCK_W  registered block returned on READ
// - BUSYWAIT   out  1        high while a request is pending/in progress
// BEHAVIOUR
// - Reset: state=IDLE, counter=0, READDATA=0, latched op/addr/data=0; BUSYWAIT forced 0 while RESET high.
// - Array contents NOT cleared by RESET; retained across reset; power-up contents undefined.
// - FSM states IDLE, ACCESS, DONE (2-bit encoding from package).
// - IDLE: BUSYWAIT = READ|WRITE (combinational, same cycle the request appears).
//   On edge with request: latch op, ADDRESS, WRITEDATA; counter<=LATENCY-1; -> ACCESS.
// - ACCESS: BUSYWAIT=1; request inputs ignored (latched copies used); counter decrements each edge.
//   Edge with counter==0: READ -> READDATA<=array[addr]; WRITE -> array[addr]<=data; -> DONE.
// - DONE: BUSYWAIT=0 for exactly one cycle; READDATA valid; next edge -> IDLE unconditionally.
// - Latency: request at cycle 0 -> BUSYWAIT high cycles 0..LATENCY, low at cycle LATENCY+1.
// - A request still asserted in DONE is not restarted; it is accepted from IDLE on the following cycle
//   (supports cache write-back immediately followed by refill read).
// - READ and WRITE both high: treated as WRITE; no read data returned.
// - Request dropped mid-ACCESS: access still completes with latched values; DONE still visited.
// - READDATA holds last read block; writes never change READDATA.
// - RESET during ACCESS: operation aborted, array not written, READDATA=0, -> IDLE next cycle.
// - Write followed by read of same address returns the newly written block (no bypass needed).
// STRUCTURE
// - Package mem_pkg: state typedef/encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2),
//   default ADDR_W/BLOCK_W constants, op encoding (OP_RD, OP_WR).
// - Sub-module mem_block_array: 2**ADDR_W x BLOCK_W storage, single port, synchronous write
//   enable, synchronous registered read with read enable; no reset on storage.
// - Top holds FSM, latency counter, request latches and BUSYWAIT decode.
// TESTING
// - Reset then READ addr 6'h00 -> BUSYWAIT 1 for 6 cycles (LATENCY=5), READDATA=array value, BUSYWAIT 0 one cycle.
// - WRITE addr 6'h2A data 32'hDEADBEEF, then READ 6'h2A -> READDATA=32'hDEADBEEF; READDATA unchanged during write.
// - Back-to-back WRITE 6'h11 then READ 6'h05 (write-back then refill) -> two full 6-cycle busy windows,
//   one idle-busy gap cycle at DONE, both completed correctly.
// - READ and WRITE both high, addr 6'h3F data 32'h12345678 -> array[6'h3F]=32'h12345678, READDATA unchanged.
// - ADDRESS/WRITEDATA changed and READ dropped in ACCESS -> original latched access completes, DONE seen.
// - RESET asserted mid-WRITE to 6'h07 -> BUSYWAIT 0, READDATA=0, array[6'h07] keeps prior value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default geometry for the block-organised data memory.
package mem_pkg;

    localparam int unsigned DEF_ADDR_W  = 6;
    localparam int unsigned DEF_BLOCK_W = 32;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/data_mem_block_if.sv
// Cache miss/write-back port of the data memory: request, block payload and BUSYWAIT handshake.
interface data_mem_block_if #(
    parameter int unsigned ADDR_W  = mem_pkg::DEF_ADDR_W,
    parameter int unsigned BLOCK_W = mem_pkg::DEF_BLOCK_W
);
    logic               READ;
    logic               WRITE;
    logic [ADDR_W-1:0]  ADDRESS;
    logic [BLOCK_W-1:0] WRITEDATA;
    logic [BLOCK_W-1:0] READDATA;
    logic               BUSYWAIT;

    modport master (output READ, WRITE, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT);
    modport slave  (input READ, WRITE, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT);
endinterface

// File: rtl/mem_block_array.sv
// Single-port block storage: synchronous write, registered read; only the read register resets.
module mem_block_array #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned BLOCK_W = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [BLOCK_W-1:0] wdata_i,
    output logic [BLOCK_W-1:0] rdata_o
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [BLOCK_W-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register holds the last block read; cleared by reset, untouched by writes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/data_mem_block.sv
// Data memory answering the data cache: fixed-latency block read/write behind a BUSYWAIT handshake.
module data_mem_block
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned BLOCK_W = DEF_BLOCK_W,
    parameter int unsigned LATENCY = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    data_mem_block_if.slave bus
);
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    op_e                op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] data_q;

    logic               req_c;
    logic               finish_c;
    logic               we_c;
    logic               re_c;
    logic               busy_c;
    logic [BLOCK_W-1:0] rdata;

    assign req_c    = bus.READ | bus.WRITE;
    assign finish_c = (state_q == ST_ACCESS) && (cnt_q == '0);
    assign we_c     = finish_c && (op_q == OP_WR) && !RESET;
    assign re_c     = finish_c && (op_q == OP_RD);

    // Request is latched on acceptance; the requester may change or drop it during ACCESS.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_RD;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_c) begin
                        op_q    <= bus.WRITE ? OP_WR : OP_RD;
                        addr_q  <= bus.ADDRESS;
                        data_q  <= bus.WRITEDATA;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // BUSYWAIT rises in the same cycle a request appears; DONE gives the one low cycle.
    always_comb begin
        busy_c = 1'b0;
        if (!RESET) begin
            case (state_q)
                ST_IDLE:   busy_c = req_c;
                ST_ACCESS: busy_c = 1'b1;
                default:   busy_c = 1'b0;
            endcase
        end
    end

    mem_block_array #(
        .ADDR_W  (ADDR_W),
        .BLOCK_W (BLOCK_W)
    ) u_array (
        .CLK     (CLK),
        .RESET   (RESET),
        .we_i    (we_c),
        .re_i    (re_c),
        .addr_i  (addr_q),
        .wdata_i (data_q),
        .rdata_o (rdata)
    );

    assign bus.READDATA = rdata;
    assign bus.BUSYWAIT = busy_c;

endmodule

// File: tb/tb_data_mem_block.sv
// Scoreboard bench for data_mem_block: latency window, read-back, write-back/refill, abort cases.
module tb_data_mem_block;

    localparam int unsigned LAT = 5;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    data_mem_block_if bus ();

    data_mem_block #(.LATENCY(LAT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [64];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;

    task automatic drive_idle();
        bus.READ      = 1'b0;
        bus.WRITE     = 1'b0;
        bus.ADDRESS   = 6'h00;
        bus.WRITEDATA = 32'h0;
    endtask

    // One request; drop_at>0 scrambles inputs and drops the request after that many busy cycles.
    task automatic req(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] d,
                       input logic hold, input int drop_at, input string name);
        int          busy_n;
        logic [31:0] exp;
        @(posedge CLK); #1;
        bus.READ      = rd;
        bus.WRITE     = wr;
        bus.ADDRESS   = a;
        bus.WRITEDATA = d;
        if (wr) model[a] = d;
        else if (rd) exp_q.push_back(model[a]);
        busy_n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.BUSYWAIT !== 1'b1) break;
            busy_n++;
            if (busy_n == drop_at) begin
                bus.READ      = 1'b0;
                bus.WRITE     = 1'b0;
                bus.ADDRESS   = ~a;
                bus.WRITEDATA = ~d;
            end
        end
        checks++;
        if (busy_n != LAT + 1) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d expected %0d", name, busy_n, LAT + 1);
        end
        checks++;
        if (rd && !wr) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard empty, READDATA got %h", name, bus.READDATA);
            end else begin
                exp = exp_q.pop_front();
                if (bus.READDATA !== exp) begin
                    errors++;
                    $display("FAIL %s READDATA got %h expected %h", name, bus.READDATA, exp);
                end
                last_rd = exp;
            end
        end else if (bus.READDATA !== last_rd) begin
            errors++;
            $display("FAIL %s READDATA changed by write got %h expected %h", name, bus.READDATA, last_rd);
        end
        if (!hold) drive_idle();
    endtask

    task automatic test_reset();
        RESET    = 1'b1;
        drive_idle();
        bus.READ = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b expected 0", bus.BUSYWAIT);
        end
        checks++;
        if (bus.READDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_readdata got %h expected 00000000", bus.READDATA);
        end
        RESET = 1'b0;
        drive_idle();
        last_rd = 32'h0;
        @(negedge CLK);
        checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy got %b expected 0", bus.BUSYWAIT);
        end
    endtask

    task automatic test_read_basic();
        req(1'b0, 1'b1, 6'h00, 32'hA5A5_0001, 1'b0, 0, "wr00");
        req(1'b1, 1'b0, 6'h00, 32'h0, 1'b0, 0, "rd00");
    endtask

    task automatic test_write_read();
        req(1'b0, 1'b1, 6'h2A, 32'hDEAD_BEEF, 1'b0, 0, "wr2a");
        req(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0, 0, "rd2a");
    endtask

    task automatic test_back_to_back();
        req(1'b0, 1'b1, 6'h05, 32'h0505_5A5A, 1'b0, 0, "pre05");
        req(1'b0, 1'b1, 6'h11, 32'h1111_AAAA, 1'b1, 0, "wb11");
        req(1'b1, 1'b0, 6'h05, 32'h0, 1'b0, 0, "refill05");
        req(1'b1, 1'b0, 6'h11, 32'h0, 1'b0, 0, "rd11");
    endtask

    task automatic test_both_high();
        req(1'b1, 1'b1, 6'h3F, 32'h1234_5678, 1'b0, 0, "both3f");
        req(1'b1, 1'b0, 6'h3F, 32'h0, 1'b0, 0, "rd3f");
    endtask

    task automatic test_drop();
        req(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0, 2, "drop2a");
        @(negedge CLK);
        checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL drop_restart busy got %b expected 0", bus.BUSYWAIT);
        end
    endtask

    task automatic test_reset_mid_write();
        req(1'b0, 1'b1, 6'h07, 32'h0000_0777, 1'b0, 0, "pre07");
        @(posedge CLK); #1;
        bus.WRITE     = 1'b1;
        bus.ADDRESS   = 6'h07;
        bus.WRITEDATA = 32'hCAFE_F00D;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        #1;
        checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got %b expected 0", bus.BUSYWAIT);
        end
        @(negedge CLK);
        checks++;
        if (bus.READDATA !== 32'h0) begin
            errors++;
            $display("FAIL abort_readdata got %h expected 00000000", bus.READDATA);
        end
        last_rd = 32'h0;
        RESET   = 1'b0;
        drive_idle();
        @(negedge CLK);
        checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle busy got %b expected 0", bus.BUSYWAIT);
        end
        req(1'b1, 1'b0, 6'h07, 32'h0, 1'b0, 0, "rd07_kept");
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_read();
        test_back_to_back();
        test_both_high();
        test_drop();
        test_reset_mid_write();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
